// File: rtl/reg_dump_unit_pkg.sv
// reg_dump_unit_pkg
//   Shared definitions for the register dump path: the dump FSM state
//   encoding, default geometry of the register bank / UART byte, and the
//   helpers that derive the per-word byte count and its counter width.
//   No ports (package).

package reg_dump_unit_pkg;

    localparam int NB_DATA_DEF    = 32;
    localparam int NB_ADDR_DEF    = 5;
    localparam int BANK_DEPTH_DEF = 32;
    localparam int NB_BYTE_DEF    = 8;

    // Number of UART bytes that make up one register word.
    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction

    // Width of the byte counter; never narrower than one bit.
    function automatic int bcnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(NB_DATA_DEF, NB_BYTE_DEF);
    localparam int NB_BCNT        = bcnt_width(BYTES_PER_WORD);

    // Dump FSM states. The encoding is also visible on the top-level
    // state register (state_q) so checkers can bind to it by name.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_LATCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT     = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } dump_state_e;

endpackage

// File: rtl/reg_word_serializer.sv
// reg_word_serializer
//   Word-to-byte datapath of the register dump: holds one register word in a
//   shift register, presents its low byte, shifts right one byte at a time
//   and counts the bytes already sent so the FSM knows when the word is done.
//
// Ports:
//   i_clock      system clock (rising edge)
//   i_reset      synchronous active-high reset; clears word and count
//   i_clear      clear the byte counter (start of dump / end of word)
//   i_load       capture i_word into the shift register
//   i_shift      drop the current low byte and count it
//   i_word       register word to serialise
//   o_byte       current low byte of the shift register
//   o_last_byte  the byte on o_byte is the final one of the word

module reg_word_serializer
    import reg_dump_unit_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_BYTE = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [NB_DATA-1:0] i_word,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_last_byte
);

    localparam int BPW    = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int NB_CNT = bcnt_width(BPW);
    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (i_load) begin
            shift_d = i_word;
        end else if (i_shift) begin
            shift_d = shift_q >> NB_BYTE;
            cnt_d   = cnt_q + NB_CNT'(1);
        end
        // Clear has priority over the count so a word boundary always
        // restarts at byte 0.
        if (i_clear) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_byte      = shift_q[NB_BYTE-1:0];
    assign o_last_byte = (cnt_q == LAST_CNT);

endmodule

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Debug-path consumer of the register bank read port. On a start request it
//   walks registers 0..BANK_DEPTH-1, reads each through o_read_reg and sends
//   it least-significant byte first to the debug UART transmitter, one
//   start/done handshake per byte.
//
// Handshake with the UART tx: o_tx_start is a one-cycle pulse and o_tx_data
//   is valid in that cycle and held until the matching i_tx_done pulse; a
//   new byte is never offered before i_tx_done, and i_tx_done is honoured
//   only while a byte is outstanding (WAIT state).
//
// Ports:
//   i_clock     system clock (rising edge)
//   i_reset     synchronous active-high reset; aborts a dump without o_done
//   i_start     dump request pulse, sampled only when idle
//   o_read_reg  register index driven to the bank read port
//   i_reg_data  bank read data for o_read_reg
//   o_tx_start  one-cycle byte start pulse to the UART tx
//   o_tx_data   byte to transmit
//   i_tx_done   one-cycle byte-sent pulse from the UART tx
//   o_busy      high while a dump is in progress (selects the bank addr mux)
//   o_done      one-cycle pulse after the last byte is acknowledged

module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NB_ADDR    = NB_ADDR_DEF,
    parameter int BANK_DEPTH = BANK_DEPTH_DEF,
    parameter int NB_BYTE    = NB_BYTE_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [NB_ADDR-1:0] o_read_reg,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    // Termination is by equality only, so BANK_DEPTH == 2**NB_ADDR works
    // without the index wrapping early.
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(BANK_DEPTH - 1);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] index_q, index_d;

    logic               ser_clear;
    logic               ser_load;
    logic               ser_shift;
    logic               ser_last;
    logic [NB_BYTE-1:0] ser_byte;

    reg_word_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_clear     (ser_clear),
        .i_load      (ser_load),
        .i_shift     (ser_shift),
        .i_word      (i_reg_data),
        .o_byte      (ser_byte),
        .o_last_byte (ser_last)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        ser_clear  = 1'b0;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        o_tx_start = 1'b0;
        o_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    index_d   = '0;
                    ser_clear = 1'b1;
                    state_d   = ST_SET_ADDR;
                end
            end
            // Address is already on o_read_reg; this cycle is the bank read.
            ST_SET_ADDR: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    ser_shift = 1'b1;
                    state_d   = ser_last ? ST_NEXT : ST_SEND;
                end
            end
            ST_NEXT: begin
                ser_clear = 1'b1;
                if (index_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + NB_ADDR'(1);
                    state_d = ST_SET_ADDR;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                index_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // The index only changes between words, so it doubles as the held
    // read address for SET_ADDR, LATCH and the whole byte stream of a word.
    assign o_read_reg = index_q;
    // Shift register low byte: valid in SEND and unchanged through WAIT.
    assign o_tx_data  = ser_byte;
    assign o_busy     = (state_q != ST_IDLE);

endmodule
